// File: rtl/mat_vect_mult_lanes.sv
// Matrix-vector multiplier: y = A*x for an N x M matrix and an M-element vector.
// x is loaded once over the vec_* stream into a register file. A is streamed
// row-major on s_axis_*, LANES elements per beat, with LANES MACs per beat.
// One dot product per row leaves on m_axis_* with full backpressure.
//
// Ports:
//   aclk, areset       clock, asynchronous active-high reset
//   vec_tdata/tvalid   vector element stream, x[0] first; vec_tready in LOAD_VEC only
//   reuse_vec          sampled on the matrix-final beat: 1 keeps x, 0 forces a reload
//   s_axis_*           matrix beats, lane k = A[r][b*LANES+k]; tlast on the final beat
//   m_axis_*           results y[r]; tlast marks y[N-1]
//   err_tlast          sticky flag: s_axis_tlast disagreed with the internal framing
//   busy               high outside LOAD_VEC or while a vector load is in progress
module mat_vect_mult_lanes #(
    parameter int unsigned N      = 4,
    parameter int unsigned M      = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned SIGNED = 0,
    localparam int unsigned OW    = 2 * DW + $clog2(M)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DW-1:0]         vec_tdata,
    input  logic                  vec_tvalid,
    output logic                  vec_tready,
    input  logic                  reuse_vec,
    input  logic [LANES*DW-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [OW-1:0]         m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err_tlast,
    output logic                  busy
);

    localparam int unsigned BEATS = M / LANES;
    localparam int unsigned VCW   = $clog2(M);
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RCW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW    = LANES * DW;
    localparam int unsigned XW    = M * DW;

    typedef enum logic {
        LOAD_VEC = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      vec_q;
    logic [VCW-1:0]     vcnt_q;
    logic [BCW-1:0]     bcnt_q;
    logic [RCW-1:0]     rcnt_q;
    logic [OW-1:0]      acc_q;

    logic               vec_hs_c, vec_last_c;
    logic               s_hs_c, beat_last_c, row_last_c;
    logic [BW-1:0]      x_beat_c;
    logic [OW-1:0]      psum_c;

    // Widen an element to OW, sign-extending only for signed operands.
    function automatic logic [OW-1:0] ext(input logic [DW-1:0] v);
        return {{(OW - DW){(SIGNED != 0) && v[DW-1]}}, v};
    endfunction

    assign vec_last_c  = (vcnt_q == VCW'(M - 1));
    assign beat_last_c = (bcnt_q == BCW'(BEATS - 1));
    assign row_last_c  = (rcnt_q == RCW'(N - 1));

    // Vector side is ready only while loading; held low during reset.
    assign vec_tready    = (state_q == LOAD_VEC) && !areset;
    // Only a row-final beat needs the output register; other beats never stall.
    assign s_axis_tready = (state_q == RUN) &&
                           (!beat_last_c || !m_axis_tvalid || m_axis_tready);
    assign vec_hs_c      = vec_tvalid && vec_tready;
    assign s_hs_c        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state_q != LOAD_VEC) || (vcnt_q != '0);

    // Partial sum of the LANES products for the current beat.
    always_comb begin
        psum_c   = '0;
        x_beat_c = vec_q[32'(bcnt_q) * BW +: BW];
        for (int k = 0; k < LANES; k++) begin
            psum_c = psum_c + ext(s_axis_tdata[k*DW +: DW]) * ext(x_beat_c[k*DW +: DW]);
        end
    end

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= LOAD_VEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_VEC: begin
                if (vec_hs_c && vec_last_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (s_hs_c && beat_last_c && row_last_c && !reuse_vec) begin
                    state_d = LOAD_VEC;
                end
            end
            default: state_d = LOAD_VEC;
        endcase
    end

    // Vector file, counters, accumulator, output register and framing flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vec_q         <= '0;
            vcnt_q        <= '0;
            bcnt_q        <= '0;
            rcnt_q        <= '0;
            acc_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_tlast     <= 1'b0;
        end else begin
            if (vec_hs_c) begin
                vec_q[32'(vcnt_q) * DW +: DW] <= vec_tdata;
                vcnt_q <= vec_last_c ? '0 : vcnt_q + VCW'(1);
            end

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end

            if (s_hs_c) begin
                if (s_axis_tlast != (row_last_c && beat_last_c)) begin
                    err_tlast <= 1'b1;
                end
                if (beat_last_c) begin
                    // A reload in the same cycle as a drain wins.
                    m_axis_tdata  <= acc_q + psum_c;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= row_last_c;
                    acc_q         <= '0;
                    bcnt_q        <= '0;
                    rcnt_q        <= row_last_c ? '0 : rcnt_q + RCW'(1);
                end else begin
                    acc_q  <= acc_q + psum_c;
                    bcnt_q <= bcnt_q + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_vect_mult_lanes.sv
// Bench for mat_vect_mult_lanes: an unsigned and a signed instance share one
// stimulus stream; each is checked against a plain-arithmetic dot-product model.
module tb_mat_vect_mult_lanes;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int DW    = 8;
    localparam int LANES = 2;
    localparam int BEATS = M / LANES;
    localparam int NB    = N * BEATS;
    localparam int OW    = 2 * DW + $clog2(M);

    logic                aclk = 1'b0;
    logic                areset;
    logic [DW-1:0]       vec_tdata;
    logic                vec_tvalid;
    logic                reuse_vec;
    logic [LANES*DW-1:0] s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                m_axis_tready = 1'b1;

    logic                vec_tready_u, s_tready_u, m_tvalid_u, m_tlast_u, err_u, busy_u;
    logic [OW-1:0]       m_tdata_u;
    logic                vec_tready_s, s_tready_s, m_tvalid_s, m_tlast_s, err_s, busy_s;
    logic [OW-1:0]       m_tdata_s;

    always #5 aclk = ~aclk;

    mat_vect_mult_lanes #(.N(N), .M(M), .DW(DW), .LANES(LANES), .SIGNED(0)) dut_u (
        .aclk(aclk), .areset(areset),
        .vec_tdata(vec_tdata), .vec_tvalid(vec_tvalid), .vec_tready(vec_tready_u),
        .reuse_vec(reuse_vec),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_tready_u),
        .m_axis_tdata(m_tdata_u), .m_axis_tvalid(m_tvalid_u),
        .m_axis_tlast(m_tlast_u), .m_axis_tready(m_axis_tready),
        .err_tlast(err_u), .busy(busy_u)
    );

    mat_vect_mult_lanes #(.N(N), .M(M), .DW(DW), .LANES(LANES), .SIGNED(1)) dut_s (
        .aclk(aclk), .areset(areset),
        .vec_tdata(vec_tdata), .vec_tvalid(vec_tvalid), .vec_tready(vec_tready_s),
        .reuse_vec(reuse_vec),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_tready_s),
        .m_axis_tdata(m_tdata_s), .m_axis_tvalid(m_tvalid_s),
        .m_axis_tlast(m_tlast_s), .m_axis_tready(m_axis_tready),
        .err_tlast(err_s), .busy(busy_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference data and expected-result scoreboards.
    logic [DW-1:0] vec_x [M];
    logic [DW-1:0] mat_a [N][M];
    logic [OW-1:0] exp_u[$];
    logic [OW-1:0] exp_s[$];
    logic          exp_lu[$];
    logic          exp_ls[$];

    // Output monitors: a transfer happens at the next rising edge.
    always @(negedge aclk) begin
        if (!areset && m_tvalid_u && m_axis_tready) begin
            if (exp_u.size() == 0) check("extra_out_u", m_tvalid_u, 1'b0);
            else begin
                check("y_u", m_tdata_u, exp_u.pop_front());
                check("tlast_u", m_tlast_u, exp_lu.pop_front());
            end
        end
        if (!areset && m_tvalid_s && m_axis_tready) begin
            if (exp_s.size() == 0) check("extra_out_s", m_tvalid_s, 1'b0);
            else begin
                check("y_s", m_tdata_s, exp_s.pop_front());
                check("tlast_s", m_tlast_s, exp_ls.pop_front());
            end
        end
    end

    // Downstream ready: 0 = always, 1 = random, 2 = scripted by bp_force.
    int   bp_mode  = 0;
    logic bp_force = 1'b1;
    always @(posedge aclk) begin
        #1;
        case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom % 4) != 0;
            default: m_axis_tready = bp_force;
        endcase
    end

    task automatic rand_vec();
        for (int i = 0; i < M; i++) vec_x[i] = ($urandom % 8 == 0) ? 8'hFF : DW'($urandom);
    endtask

    task automatic rand_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                mat_a[r][c] = ($urandom % 8 == 0) ? 8'h80 : DW'($urandom);
    endtask

    task automatic load_vec(input bit gaps);
        int cyc;
        for (int i = 0; i < M; i++) begin
            if (gaps) while ($urandom % 3 == 0) begin vec_tvalid = 1'b0; @(posedge aclk); #1; end
            vec_tvalid = 1'b1;
            vec_tdata  = vec_x[i];
            cyc = 0;
            @(negedge aclk);
            while (!vec_tready_u && cyc < 100) begin cyc++; @(negedge aclk); end
            if (!vec_tready_u) begin
                check("vec_timeout", vec_tready_u, 1'b1);
                vec_tvalid = 1'b0;
                return;
            end
            @(posedge aclk); #1;
        end
        vec_tvalid = 1'b0;
    endtask

    // Push model results, then stream the matrix; tlast goes on beat tlast_at.
    task automatic send_matrix(input int tlast_at, input bit reuse, input bit gaps);
        int cyc;
        logic [LANES*DW-1:0] beat;
        longint su, ss;
        for (int r = 0; r < N; r++) begin
            su = 0;
            ss = 0;
            for (int c = 0; c < M; c++) begin
                su += longint'(mat_a[r][c]) * longint'(vec_x[c]);
                ss += longint'($signed(mat_a[r][c])) * longint'($signed(vec_x[c]));
            end
            exp_u.push_back(OW'(su));
            exp_s.push_back(OW'(ss));
            exp_lu.push_back(r == N - 1);
            exp_ls.push_back(r == N - 1);
        end
        for (int b = 0; b < NB; b++) begin
            if (gaps) while ($urandom % 3 == 0) begin s_axis_tvalid = 1'b0; @(posedge aclk); #1; end
            for (int k = 0; k < LANES; k++) beat[k*DW +: DW] = mat_a[b / BEATS][(b % BEATS) * LANES + k];
            s_axis_tdata  = beat;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (b == tlast_at);
            reuse_vec     = (b == NB - 1) ? reuse : 1'($urandom);
            cyc = 0;
            @(negedge aclk);
            while (!s_tready_u && cyc < 100) begin
                check("stall_pos", 64'(b % BEATS), 64'(BEATS - 1));
                stall_cnt++;
                cyc++;
                @(negedge aclk);
            end
            if (!s_tready_u) begin
                check("s_timeout", s_tready_u, 1'b1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        reuse_vec     = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_u.size() != 0 || exp_s.size() != 0) && cyc < 300) begin
            @(negedge aclk);
            cyc++;
        end
        if (exp_u.size() != 0) check("drain_u", 64'(exp_u.size()), 0);
        if (exp_s.size() != 0) check("drain_s", 64'(exp_s.size()), 0);
        @(posedge aclk); #1;
    endtask

    task automatic set_test1();
        vec_x = '{8'd1, 8'd2, 8'd3, 8'd4};
        mat_a = '{'{8'd1, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0, 8'd0},
                  '{8'd1, 8'd1, 8'd1, 8'd1}, '{8'd4, 8'd3, 8'd2, 8'd1}};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  reused;
        bit  r;
        areset = 1'b1; vec_tdata = '0; vec_tvalid = 1'b0; reuse_vec = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", m_tvalid_u, 1'b0);
        check("rst_tdata", m_tdata_u, '0);
        check("rst_tlast", m_tlast_u, 1'b0);
        check("rst_err", err_u, 1'b0);
        check("rst_s_tready", s_tready_u, 1'b0);
        check("rst_vec_tready", vec_tready_u, 1'b0);
        check("rst_busy", busy_u, 1'b0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("post_rst_vec_tready", vec_tready_u, 1'b1);
        check("post_rst_busy", busy_u, 1'b0);
        @(posedge aclk); #1;

        // Directed: y = 1, 2, 10, 20.
        set_test1();
        load_vec(1'b0);
        @(negedge aclk);
        check("run_vec_tready", vec_tready_u, 1'b0);
        check("run_busy", busy_u, 1'b1);
        @(posedge aclk); #1;
        send_matrix(NB - 1, 1'b0, 1'b0);
        drain();
        check("t1_err", err_u, 1'b0);
        check("t1_reload_ready", vec_tready_u, 1'b1);
        check("t1_idle", busy_u, 1'b0);

        // Full-scale operands.
        for (int i = 0; i < M; i++) vec_x[i] = 8'hFF;
        for (int rr = 0; rr < N; rr++) for (int c = 0; c < M; c++) mat_a[rr][c] = 8'hFF;
        load_vec(1'b1);
        send_matrix(NB - 1, 1'b0, 1'b1);
        drain();

        // Signed corner rows.
        vec_x = '{8'hFF, 8'h02, 8'hFD, 8'h04};
        rand_mat();
        for (int c = 0; c < M; c++) begin mat_a[0][c] = 8'h01; mat_a[1][c] = 8'h80; end
        load_vec(1'b0);
        send_matrix(NB - 1, 1'b0, 1'b0);
        drain();

        // Output held for 10 cycles after y[0].
        set_test1();
        load_vec(1'b0);
        bp_mode = 2; bp_force = 1'b0;
        stall_cnt = 0;
        fork
            send_matrix(NB - 1, 1'b0, 1'b0);
            begin
                cyc = 0;
                @(negedge aclk);
                while (!m_tvalid_u && cyc < 50) begin cyc++; @(negedge aclk); end
                for (int i = 0; i < 10; i++) begin
                    check("hold_valid", m_tvalid_u, 1'b1);
                    check("hold_data", m_tdata_u, 64'd1);
                    @(negedge aclk);
                end
                bp_force = 1'b1;
            end
        join
        drain();
        bp_mode = 0;
        check("bp_stalled", 64'(stall_cnt > 0), 1'b1);

        // Vector reuse across two back-to-back matrices.
        rand_vec(); rand_mat();
        load_vec(1'b0);
        send_matrix(NB - 1, 1'b1, 1'b0);
        vec_tvalid = 1'b1; vec_tdata = 8'h55;
        @(negedge aclk);
        check("reuse_vec_tready", vec_tready_u, 1'b0);
        check("reuse_busy", busy_u, 1'b1);
        @(posedge aclk); #1;
        vec_tvalid = 1'b0;
        rand_mat();
        send_matrix(NB - 1, 1'b0, 1'b0);
        @(negedge aclk);
        check("noreuse_vec_tready", vec_tready_u, 1'b1);
        @(posedge aclk); #1;
        drain();

        // Random traffic with random backpressure and reuse.
        bp_mode = 1;
        reused  = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (!reused) begin
                rand_vec();
                load_vec(1'b1);
            end else begin
                @(negedge aclk);
                check("rand_reuse_vec_tready", vec_tready_u, 1'b0);
                @(posedge aclk); #1;
            end
            rand_mat();
            r = (t == 7) ? 1'b0 : 1'($urandom);
            send_matrix(NB - 1, r, 1'b1);
            reused = r;
        end
        drain();
        bp_mode = 0;
        check("rand_err", err_u, 1'b0);

        // Early tlast on beat 3: sticky error, all rows still produced.
        rand_vec(); rand_mat();
        load_vec(1'b0);
        send_matrix(3, 1'b0, 1'b0);
        drain();
        check("frame_err_u", err_u, 1'b1);
        check("frame_err_s", err_s, 1'b1);

        // Reset in the middle of a matrix.
        rand_vec();
        load_vec(1'b0);
        s_axis_tdata = 16'h1234; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("mid_rst_tvalid", m_tvalid_u, 1'b0);
        check("mid_rst_tdata", m_tdata_u, '0);
        check("mid_rst_err", err_u, 1'b0);
        check("mid_rst_busy", busy_u, 1'b0);
        check("mid_rst_s_tready", s_tready_u, 1'b0);
        @(posedge aclk); @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("mid_rst_vec_tready", vec_tready_u, 1'b1);
        check("mid_rst_idle", busy_u, 1'b0);
        @(posedge aclk); #1;

        // Fresh matrix after reset starts from a clean accumulator.
        set_test1();
        load_vec(1'b0);
        send_matrix(NB - 1, 1'b0, 1'b0);
        drain();
        check("final_err", err_u, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_vect_mult_lanes.md
Name: mat_vect_mult_lanes

Overview:
- Parametrised successor to the single-lane matrix-vector multiplier: computes y = A·x for an N×M matrix A and an M-element vector x.
- x is loaded once over a dedicated stream port into an internal register file.
- A streams in row-major over AXI-Stream, LANES elements per beat, with LANES parallel MACs per beat.
- Emits one dot product per row on an AXI-Stream master with full backpressure support, optional signed arithmetic, vector retention across matrices, and framing-error detection.

Parameters:
- N, 4, number of matrix rows (output beats per matrix), ≥1
- M, 4, number of matrix columns / vector length, ≥2, divisible by LANES
- DW, 8, element width (matrix and vector)
- LANES, 2, matrix elements per input beat; 1 ≤ LANES ≤ M
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and result
- OW, 2*DW+$clog2(M), result width (derived, not overridable)

Ports:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- vec_tdata  in  DW  vector element, x[0] first
- vec_tvalid  in  1  vector element valid
- vec_tready  out  1  high only in LOAD_VEC
- reuse_vec  in  1  sampled at end of matrix: 1 = keep x, 0 = reload x
- s_axis_tdata  in  LANES*DW  matrix elements; lane k at bits [k*DW +: DW] = A[r][b*LANES+k]
- s_axis_tvalid  in  1  matrix beat valid
- s_axis_tlast  in  1  asserted by source on final beat of the matrix
- s_axis_tready  out  1  matrix beat accept
- m_axis_tdata  out  OW  y[r]
- m_axis_tvalid  out  1  result valid
- m_axis_tlast  out  1  marks y[N-1]
- m_axis_tready  in  1  downstream accept
- err_tlast  out  1  sticky framing error
- busy  out  1  high when state != LOAD_VEC or the vector count is nonzero

Behaviour:
- Reset: all outputs 0; state LOAD_VEC; vector count, beat count and row count 0; accumulator 0; vector registers 0.

State machine (2 states):
- LOAD_VEC:
  - vec_tready=1, s_axis_tready=0.
  - Each vec handshake writes x[vcnt] and increments vcnt.
  - On handshake with vcnt==M-1: vcnt←0, go to RUN.
- RUN:
  - vec_tready=0.
  - Matrix beats are accepted per the handshake rule below.
  - On acceptance of the final beat of row N-1: if reuse_vec==1 stay in RUN; else go to LOAD_VEC.

Handshake and accumulation:
- s_axis_tready = RUN && (bcnt != M/LANES-1 || !m_axis_tvalid || m_axis_tready). The stream stalls only on a row-final beat while the output register is occupied.
- Per accepted beat: psum = Σk A·x[bcnt*LANES+k], products and sum computed at OW width, sign-extended when SIGNED=1.
- Non-final beat of a row: acc←acc+psum; bcnt++.
- Row-final beat:
  - m_axis_tdata←acc+psum; m_axis_tvalid←1; m_axis_tlast←(rcnt==N-1).
  - acc←0; bcnt←0; rcnt←(rcnt==N-1)?0:rcnt+1.
- Latency: y[r] is valid the cycle after the row-final beat is accepted.
- Output register: holds tdata/tvalid/tlast stable until m_axis_tready; clears tvalid/tlast on handshake unless reloaded in the same cycle (load wins).
- Rows stream back-to-back at full rate when m_axis_tready=1.
- Overflow is impossible by OW sizing. Unsigned max is M·(2^DW−1)^2; for SIGNED=1 the result is exact two's-complement at OW.

Framing:
- err_tlast sets when an accepted beat has s_axis_tlast != (rcnt==N-1 && bcnt==M/LANES-1).
- err_tlast is sticky until areset.
- Internal counters alone govern framing; tlast never truncates or extends a matrix.

Boundary cases:
- Vector words offered during RUN are not accepted (vec_tready=0).
- reuse_vec is sampled only on the matrix-final beat.
- Reset mid-row or mid-load aborts everything. Partial acc and x are discarded; a new vector load is required.
- LANES==M: every beat is row-final.

Test Plan:
- N=M=4, LANES=2, DW=8, SIGNED=0. x=[1,2,3,4]; A rows [1,0,0,0],[0,1,0,0],[1,1,1,1],[4,3,2,1] -> y=1,2,10,20; tlast only on 20; err_tlast=0.
- Max values: x all 255, A all 255 -> each y=260100 (0x3F804, fits OW=18); no wrap.
- SIGNED=1: x=[-1,2,-3,4] (0xFF,0x02,0xFD,0x04); A row [1,1,1,1] -> y=2; row [-128,-128,-128,-128] -> y=-256, i.e. 18'h3FF00.
- Backpressure: hold m_axis_tready=0 for 10 cycles after y[0] -> s_axis_tready drops only on row-1 final beat; y[0] stays stable; no data lost; results identical to the first test.
- reuse_vec=1 with two back-to-back matrices -> second matrix needs no vector load, vec_tready stays 0. With reuse_vec=0 -> vec_tready=1 after the matrix-final beat.
- s_axis_tlast asserted on beat 3 of 8 -> err_tlast=1 from next cycle, all 4 outputs still produced; assert areset mid-row -> all outputs 0, vec_tready=1 after release.
